// File: rtl/status_queue.sv
// Packet-header status queue with register-mapped readout and saturating per-type/drop statistics.
// Optional per-entry cycle timestamp enabled by defining STATUS_QUEUE_TIMESTAMP_EN.
module status_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pkt_valid,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  input  logic [47:0] i_SHA,
  input  logic [47:0] i_THA,
  input  logic [31:0] i_SPA,
  input  logic [31:0] i_TPA,
  input  logic [1:0]  i_operation,
  input  logic [1:0]  i_packet_type,
  input  logic [7:0]  i_rx_cmd_addr,
  input  logic        i_rx_pkt_rd,
  output logic [31:0] o_rx_pkt_data,
  output logic        o_not_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [AW:0]      OCC_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]      OCC_FULL = (AW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [47:0] r_dst_mac [DEPTH];
  logic [47:0] r_src_mac [DEPTH];
  logic [47:0] r_sha     [DEPTH];
  logic [47:0] r_tha     [DEPTH];
  logic [31:0] r_spa     [DEPTH];
  logic [31:0] r_tpa     [DEPTH];
  logic [1:0]  r_op      [DEPTH];
  logic [1:0]  r_ptype   [DEPTH];

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic [CNT_W-1:0] r_type_cnt [4];
  logic [CNT_W-1:0] r_drop_cnt;
  logic [31:0]      r_rd_data;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic [31:0] w_rd_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == OCC_FULL);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_pop   = i_rx_pkt_rd && !w_empty;
  assign w_push  = i_pkt_valid && (!w_full || i_rx_pkt_rd);
  assign w_drop  = i_pkt_valid && w_full && !i_rx_pkt_rd;

  assign o_not_empty   = !w_empty;
  assign o_rx_pkt_data = r_rd_data;

`ifdef STATUS_QUEUE_TIMESTAMP_EN
  logic [31:0] r_cycle;
  logic [31:0] r_ts [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) r_cycle <= '0;
    else     r_cycle <= r_cycle + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_ts[r_wptr] <= r_cycle;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_dst_mac[r_wptr] <= i_dst_mac;
      r_src_mac[r_wptr] <= i_src_mac;
      r_sha[r_wptr]     <= i_SHA;
      r_tha[r_wptr]     <= i_THA;
      r_spa[r_wptr]     <= i_SPA;
      r_tpa[r_wptr]     <= i_TPA;
      r_op[r_wptr]      <= i_operation;
      r_ptype[r_wptr]   <= i_packet_type;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) r_type_cnt[k] <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (i_pkt_valid && (r_type_cnt[i_packet_type] != '1))
        r_type_cnt[i_packet_type] <= r_type_cnt[i_packet_type] + CNT_ONE;
      if (w_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + CNT_ONE;
      // Drop needs rd low and the clear needs rd high, so the two never collide.
      if (w_drop)
        r_ovf <= 1'b1;
      else if (i_rx_pkt_rd && (i_rx_cmd_addr == 8'h00))
        r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (i_rx_cmd_addr)
      8'h00: w_rd_data = {22'd0, r_ovf, w_full, 8'(r_count)};
      8'h01: if (!w_empty) w_rd_data = r_dst_mac[r_rptr][31:0];
      8'h02: if (!w_empty) w_rd_data = {16'd0, r_dst_mac[r_rptr][47:32]};
      8'h03: if (!w_empty) w_rd_data = r_src_mac[r_rptr][31:0];
      8'h04: if (!w_empty) w_rd_data = {16'd0, r_src_mac[r_rptr][47:32]};
      8'h05: if (!w_empty) w_rd_data = {30'd0, r_op[r_rptr]};
      8'h06: if (!w_empty) w_rd_data = r_sha[r_rptr][31:0];
      8'h07: if (!w_empty) w_rd_data = {16'd0, r_sha[r_rptr][47:32]};
      8'h08: if (!w_empty) w_rd_data = r_spa[r_rptr];
      8'h09: if (!w_empty) w_rd_data = r_tha[r_rptr][31:0];
      8'h0A: if (!w_empty) w_rd_data = {16'd0, r_tha[r_rptr][47:32]};
      8'h0B: if (!w_empty) w_rd_data = r_tpa[r_rptr];
      8'h0C: if (!w_empty) w_rd_data = {30'd0, r_ptype[r_rptr]};
`ifdef STATUS_QUEUE_TIMESTAMP_EN
      8'h0D: if (!w_empty) w_rd_data = r_ts[r_rptr];
`endif
      8'h10: w_rd_data = 32'(r_type_cnt[0]);
      8'h11: w_rd_data = 32'(r_type_cnt[1]);
      8'h12: w_rd_data = 32'(r_type_cnt[2]);
      8'h13: w_rd_data = 32'(r_type_cnt[3]);
      8'h14: w_rd_data = 32'(r_drop_cnt);
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= w_rd_data;
  end

endmodule
